// File: rtl/gol_pkg.sv
// Shared types and board constants for the Game of Life generation scheduler.
package gol_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitVb,
        StStep,
        StSeed,
        StScore
    } gol_sched_state_t;

    localparam int unsigned GOL_WIDTH  = 10;
    localparam int unsigned GOL_HEIGHT = 9;

endpackage

// File: rtl/gol_period_timer.sv
// Generation-period counter: counts enabled cycles while running and emits a one-cycle tick
// every period; the period is captured at each reload so changes apply from the next period.
module gol_period_timer #(
    parameter int unsigned PERIOD_W = 25
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                count_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] per_eff;

    // Periods of 0 and 1 both mean a tick on every counting cycle.
    assign per_eff = (period_i > PERIOD_W'(1)) ? period_i : PERIOD_W'(1);

    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        tick_o = 1'b0;
        if (!run_i) begin
            cnt_d = '0;
            per_d = per_eff;
        end else if (count_en_i) begin
            if (cnt_q >= per_q - PERIOD_W'(1)) begin
                tick_o = 1'b1;
                cnt_d  = '0;
                per_d  = per_eff;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            per_q <= PERIOD_W'(1);
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/gol_gen_sched.sv
// Generation scheduler: aligns board steps and seed reloads to vertical blanking.
// Build option GOL_GEN_SCHED_AUTOSEED_EN: reseed automatically when a step leaves the board empty.
module gol_gen_sched
    import gol_pkg::*;
#(
    parameter int unsigned PERIOD_W = 25,
    parameter int unsigned GEN_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic                step_cmd_i,
    input  logic                seed_cmd_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                vblank_i,
    output logic                step_en_o,
    input  logic                step_done_i,
    output logic                seed_en_o,
    input  logic                seed_done_i,
    output logic                score_en_o,
    input  logic                board_empty_i,
    output logic [GEN_W-1:0]    gen_count_o,
    output logic                busy_o
);

    gol_sched_state_t state_q, state_d;
    logic             gen_pend_q, gen_pend_d;
    logic             seed_pend_q, seed_pend_d;
    logic             step_en_q, step_en_d;
    logic             seed_en_q, seed_en_d;
    logic             score_en_q, score_en_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic             gen_clr, seed_clr, auto_seed, tick;

    gol_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_period_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (run_i),
        .count_en_i (state_q == StIdle),
        .period_i   (period_i),
        .tick_o     (tick)
    );

`ifndef GOL_GEN_SCHED_AUTOSEED_EN
    logic unused_board_empty;
    assign unused_board_empty = board_empty_i;
`endif

    always_comb begin
        state_d     = state_q;
        gen_count_d = gen_count_q;
        gen_clr     = 1'b0;
        seed_clr    = 1'b0;
        auto_seed   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (seed_pend_q || gen_pend_q) state_d = StWaitVb;
            end
            StWaitVb: begin
                if (vblank_i) begin
                    if (seed_pend_q) begin
                        seed_clr = 1'b1;
                        state_d  = StSeed;
                    end else begin
                        gen_clr = 1'b1;
                        state_d = StStep;
                    end
                end
            end
            StStep: begin
                if (step_done_i) begin
                    gen_count_d = gen_count_q + GEN_W'(1);
                    state_d     = StScore;
                end
            end
            StSeed: begin
                if (seed_done_i) begin
                    gen_count_d = '0;
                    state_d     = StIdle;
                end
            end
            StScore: begin
                state_d = StIdle;
`ifdef GOL_GEN_SCHED_AUTOSEED_EN
                auto_seed = board_empty_i;
`endif
            end
            default: state_d = StIdle;
        endcase

        // A fresh request arriving on the service cycle survives the clear (merge, no loss).
        gen_pend_d  = (gen_pend_q & ~gen_clr) | tick | (step_cmd_i & ~run_i);
        seed_pend_d = (seed_pend_q & ~seed_clr) | seed_cmd_i | auto_seed;
        step_en_d   = (state_q == StStep) && !step_done_i;
        seed_en_d   = (state_q == StSeed) && !seed_done_i;
        score_en_d  = (state_d == StScore);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            gen_pend_q  <= 1'b0;
            seed_pend_q <= 1'b0;
            step_en_q   <= 1'b0;
            seed_en_q   <= 1'b0;
            score_en_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            gen_pend_q  <= gen_pend_d;
            seed_pend_q <= seed_pend_d;
            step_en_q   <= step_en_d;
            seed_en_q   <= seed_en_d;
            score_en_q  <= score_en_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign step_en_o   = step_en_q;
    assign seed_en_o   = seed_en_q;
    assign score_en_o  = score_en_q;
    assign gen_count_o = gen_count_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_gol_gen_sched.sv
// Self-checking bench for gol_gen_sched: cycle vector table plus multi-cycle scenario sequences.
module tb_gol_gen_sched;

    localparam int unsigned PeriodW = 25;
    localparam int unsigned GenW    = 4;
    localparam int          AckDly  = 3;
    localparam int          Period  = 8;
    // IDLE counting cycles + WAIT_VB + STEP (entry cycle + ack wait) + SCORE.
    localparam int          FreeRunInterval = Period + 1 + (1 + AckDly) + 1;

    logic               clk;
    logic               rst;
    logic               run;
    logic               step_cmd;
    logic               seed_cmd;
    logic [PeriodW-1:0] period;
    logic               vblank;
    logic               step_en;
    logic               step_done;
    logic               seed_en;
    logic               seed_done;
    logic               score_en;
    logic               board_empty;
    logic [GenW-1:0]    gen_count;
    logic               busy;

    logic board_auto = 1'b0;
    logic m_step_done = 1'b0;
    logic m_seed_done = 1'b0;
    logic b_step_done = 1'b0;
    logic b_seed_done = 1'b0;
    int   b_step_cnt = 0;
    int   b_seed_cnt = 0;
    int   score_cnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    assign step_done = board_auto ? b_step_done : m_step_done;
    assign seed_done = board_auto ? b_seed_done : m_seed_done;

    gol_gen_sched #(
        .PERIOD_W (PeriodW),
        .GEN_W    (GenW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .run_i         (run),
        .step_cmd_i    (step_cmd),
        .seed_cmd_i    (seed_cmd),
        .period_i      (period),
        .vblank_i      (vblank),
        .step_en_o     (step_en),
        .step_done_i   (step_done),
        .seed_en_o     (seed_en),
        .seed_done_i   (seed_done),
        .score_en_o    (score_en),
        .board_empty_i (board_empty),
        .gen_count_o   (gen_count),
        .busy_o        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Board model: acknowledges each request AckDly cycles after it is first seen.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (score_en) score_cnt++;
            if (board_auto) begin
                if (b_step_done) begin
                    b_step_done = 1'b0;
                    b_step_cnt  = 0;
                end else if (step_en) begin
                    b_step_cnt++;
                    if (b_step_cnt == AckDly) b_step_done = 1'b1;
                end else begin
                    b_step_cnt = 0;
                end
                if (b_seed_done) begin
                    b_seed_done = 1'b0;
                    b_seed_cnt  = 0;
                end else if (seed_en) begin
                    b_seed_cnt++;
                    if (b_seed_cnt == AckDly) b_seed_done = 1'b1;
                end else begin
                    b_seed_cnt = 0;
                end
            end else begin
                b_step_done = 1'b0;
                b_seed_done = 1'b0;
                b_step_cnt  = 0;
                b_seed_cnt  = 0;
            end
        end
    end

    typedef struct {
        logic       run;
        logic       step;
        logic       seed;
        logic       vb;
        logic       sdone;
        logic       ddone;
        logic [7:0] exp;   // {step_en, seed_en, score_en, busy, gen_count}
    } vec_t;

    function automatic vec_t mk(input logic r, input logic st, input logic sd, input logic vb,
                                input logic sdn, input logic ddn, input logic es, input logic ed,
                                input logic esc, input logic eb, input logic [3:0] gc);
        vec_t v;
        v.run   = r;
        v.step  = st;
        v.seed  = sd;
        v.vb    = vb;
        v.sdone = sdn;
        v.ddone = ddn;
        v.exp   = {es, ed, esc, eb, gc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_sig(input int which, input logic val, input int max_cyc,
                            input string name);
        logic s;
        bit   ok;
        ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge clk);
            #1;
            case (which)
                0:       s = step_en;
                1:       s = seed_en;
                2:       s = busy;
                default: s = score_en;
            endcase
            if (s === val) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles, level %0b never seen", name, max_cyc,
                     val);
        end
    endtask

    task automatic do_step();
        step_cmd = 1'b1;
        @(posedge clk);
        #1;
        step_cmd = 1'b0;
        wait_sig(2, 1'b1, 10, "step_busy");
        wait_sig(2, 1'b0, 40, "step_idle");
    endtask

    vec_t vecs[21];
    int   t_prev;
    int   score0;
    int   hits;

    initial begin
        rst         = 1'b1;
        run         = 1'b0;
        step_cmd    = 1'b0;
        seed_cmd    = 1'b0;
        period      = PeriodW'(Period);
        vblank      = 1'b0;
        board_empty = 1'b0;

        //              run st sd vb sdn ddn | sten seen scen busy gc
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'd0);
        vecs[5]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 4'd0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4'd0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 4'd1);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd1);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd1);
        vecs[11] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'd1);
        vecs[12] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'd1);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4'd1);
        vecs[14] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 4'd1);
        vecs[15] = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 4'd1);
        vecs[16] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 4'd0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[18] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);

        #12;
        chk("reset_state", {24'd0, step_en, seed_en, score_en, busy, gen_count}, 32'd0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            run         = vecs[i].run;
            step_cmd    = vecs[i].step;
            seed_cmd    = vecs[i].seed;
            vblank      = vecs[i].vb;
            m_step_done = vecs[i].sdone;
            m_seed_done = vecs[i].ddone;
            @(posedge clk);
            #1;
            checks++;
            if ({step_en, seed_en, score_en, busy, gen_count} !== vecs[i].exp) begin
                errors++;
                $display("FAIL vec%0d: got {sten,seen,scen,busy,gc}=%b required %b", i,
                         {step_en, seed_en, score_en, busy, gen_count}, vecs[i].exp);
            end
        end
        step_cmd    = 1'b0;
        seed_cmd    = 1'b0;
        m_step_done = 1'b0;
        m_seed_done = 1'b0;

        // Free-running generations with vblank held high.
        board_auto = 1'b1;
        vblank     = 1'b1;
        score0     = score_cnt;
        run        = 1'b1;
        wait_sig(0, 1'b1, 60, "fr_rise0");
        t_prev = cyc;
        chk("fr_gc0", 32'(gen_count), 32'd0);
        for (int k = 1; k < 4; k++) begin
            wait_sig(0, 1'b0, 20, "fr_fall");
            wait_sig(0, 1'b1, 40, "fr_rise");
            chk($sformatf("fr_interval%0d", k), 32'(cyc - t_prev), 32'(FreeRunInterval));
            t_prev = cyc;
            chk($sformatf("fr_gc%0d", k), 32'(gen_count), 32'(k));
        end
        for (int n = 0; n < 40 && (score_cnt - score0) < 4; n++) begin
            @(posedge clk);
            #1;
        end
        run = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("fr_gc_final", 32'(gen_count), 32'd4);
        chk("fr_scores", 32'(score_cnt - score0), 32'd4);
        chk("fr_idle", {31'd0, busy}, 32'd0);

        // Step and seed requested together: seed first, then the step.
        score0   = score_cnt;
        step_cmd = 1'b1;
        seed_cmd = 1'b1;
        @(posedge clk);
        #1;
        step_cmd = 1'b0;
        seed_cmd = 1'b0;
        wait_sig(1, 1'b1, 20, "sim_seed_rise");
        chk("sim_step_not_first", {31'd0, step_en}, 32'd0);
        wait_sig(1, 1'b0, 20, "sim_seed_fall");
        chk("sim_gc_after_seed", 32'(gen_count), 32'd0);
        chk("sim_no_score_seed", 32'(score_cnt - score0), 32'd0);
        wait_sig(0, 1'b1, 20, "sim_step_rise");
        wait_sig(2, 1'b0, 20, "sim_idle");
        chk("sim_gc_after_step", 32'(gen_count), 32'd1);
        chk("sim_score_step", 32'(score_cnt - score0), 32'd1);

        // Reset while the board holds a step request.
        board_auto = 1'b0;
        step_cmd   = 1'b1;
        @(posedge clk);
        #1;
        step_cmd = 1'b0;
        wait_sig(0, 1'b1, 20, "rst_step_rise");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_step_en", {31'd0, step_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_gc", 32'(gen_count), 32'd0);
        #3;
        rst  = 1'b0;
        hits = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (step_en || seed_en || busy) hits++;
        end
        chk("rst_no_spurious", 32'(hits), 32'd0);

        // Generation counter wrap.
        board_auto = 1'b1;
        for (int n = 0; n < 15; n++) do_step();
        chk("wrap_gc15", 32'(gen_count), 32'd15);
        do_step();
        chk("wrap_gc0", 32'(gen_count), 32'd0);

        // Extinct board after a step.
        board_empty = 1'b1;
        do_step();
`ifdef GOL_GEN_SCHED_AUTOSEED_EN
        wait_sig(1, 1'b1, 20, "auto_seed_rise");
        wait_sig(1, 1'b0, 20, "auto_seed_fall");
        chk("auto_gc", 32'(gen_count), 32'd0);
`else
        hits = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (seed_en) hits++;
        end
        chk("no_auto_seed", 32'(hits), 32'd0);
        chk("no_auto_gc", 32'(gen_count), 32'd1);
`endif
        board_empty = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
